show_sched: RTL and testbench

Single-clock scheduler for the board light-show engines: the HEX message engine, the LEDG blink engine and the LEDR wave engine. It owns the only timebase prescaler and runs the show as a fixed sequence: message, then blink, then wave. At any time exactly one engine is enabled, and it receives a one-cycle step strobe plus a step index. This replaces the per-engine divided clocks with clock enables in the `ck` domain.

---
 rtl/show_sched.sv | 152 +++++++++++++++
 tb/tb_show_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/show_sched.sv
// show_sched: single-clock scheduler for the light-show engines.
// Runs MSG -> BLINK -> WAVE, handing one engine at a time a one-cycle step
// strobe (tick) and a step index (phase), all derived from one prescaler.
// Build option: define SHOW_LOOP_EN to loop WAVE back to MSG while run is
// high; otherwise WAVE exits to IDLE and the show waits for run 0 -> 1.
module show_sched #(
  parameter int TICK_DIV    = 5000000,
  parameter int MSG_TICKS   = 20,
  parameter int BLINK_TICKS = 16,
  parameter int WAVE_STEPS  = 36
) (
  input  logic       ck,
  input  logic       rs_n,
  input  logic       run,
  input  logic       hold,
  input  logic       skip,
  output logic       en_msg,
  output logic       en_blink,
  output logic       en_wave,
  output logic       tick,
  output logic [7:0] phase,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MSG   = 2'd1;
  localparam logic [1:0] S_BLINK = 2'd2;
  localparam logic [1:0] S_WAVE  = 2'd3;

  logic [1:0]    state_r;
  logic [PW-1:0] presc_r;
  logic          armed_r;

  logic [1:0]    state_nx_s;
  logic [PW-1:0] presc_nx_s;
  logic [7:0]    phase_nx_s;
  logic          tick_nx_s;
  logic          done_nx_s;
  logic          armed_nx_s;
  logic [1:0]    mode_after_s;

  // Last phase index of a mode (dwell - 1).
  function automatic logic [7:0] last_phase(input logic [1:0] st);
    case (st)
      S_MSG:   return 8'(MSG_TICKS - 1);
      S_BLINK: return 8'(BLINK_TICKS - 1);
      S_WAVE:  return 8'(WAVE_STEPS - 1);
      default: return 8'd0;
    endcase
  endfunction

  // Mode that follows the given one in the show order.
  function automatic logic [1:0] next_mode(input logic [1:0] st);
    case (st)
      S_MSG:   return S_BLINK;
      S_BLINK: return S_WAVE;
`ifdef SHOW_LOOP_EN
      S_WAVE:  return S_MSG;
`else
      S_WAVE:  return S_IDLE;
`endif
      default: return S_IDLE;
    endcase
  endfunction

  // Next-state logic: run beats skip beats hold beats the prescaler step.
  always_comb begin
    state_nx_s   = state_r;
    presc_nx_s   = presc_r;
    phase_nx_s   = phase;
    tick_nx_s    = 1'b0;
    done_nx_s    = 1'b0;
    armed_nx_s   = armed_r;
    mode_after_s = next_mode(state_r);
    if (!run) begin
      state_nx_s = S_IDLE;
      presc_nx_s = '0;
      phase_nx_s = 8'd0;
      armed_nx_s = 1'b1;
    end else if (state_r == S_IDLE) begin
      if (armed_r) begin
        state_nx_s = S_MSG;
        presc_nx_s = '0;
        phase_nx_s = 8'd0;
      end else begin
        state_nx_s = S_IDLE;
      end
    end else if (skip) begin
      // Abandon the mode; any step landing this cycle is swallowed.
      state_nx_s = mode_after_s;
      presc_nx_s = '0;
      phase_nx_s = 8'd0;
      if (mode_after_s == S_IDLE) begin
        armed_nx_s = 1'b0;
      end else begin
        armed_nx_s = armed_r;
      end
    end else if (hold) begin
      state_nx_s = state_r;
    end else if (presc_r == PRESC_LAST) begin
      presc_nx_s = '0;
      tick_nx_s  = 1'b1;
      if (phase < last_phase(state_r)) begin
        phase_nx_s = phase + 8'd1;
      end else begin
        state_nx_s = mode_after_s;
        phase_nx_s = 8'd0;
        if (state_r == S_WAVE) begin
          done_nx_s = 1'b1;
        end else begin
          done_nx_s = 1'b0;
        end
        if (mode_after_s == S_IDLE) begin
          armed_nx_s = 1'b0;
        end else begin
          armed_nx_s = armed_r;
        end
      end
    end else begin
      presc_nx_s = presc_r + PW'(1);
    end
  end

  // State, counters and registered outputs; synchronous active-low reset.
  always_ff @(posedge ck) begin
    if (!rs_n) begin
      state_r  <= S_IDLE;
      presc_r  <= '0;
      armed_r  <= 1'b1;
      phase    <= 8'd0;
      tick     <= 1'b0;
      done     <= 1'b0;
      en_msg   <= 1'b0;
      en_blink <= 1'b0;
      en_wave  <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      presc_r  <= presc_nx_s;
      armed_r  <= armed_nx_s;
      phase    <= phase_nx_s;
      tick     <= tick_nx_s;
      done     <= done_nx_s;
      en_msg   <= (state_nx_s == S_MSG);
      en_blink <= (state_nx_s == S_BLINK);
      en_wave  <= (state_nx_s == S_WAVE);
    end
  end

endmodule

// File: tb/tb_show_sched.sv
// Directed bench for show_sched with TICK_DIV=4, MSG=3, BLINK=2, WAVE=5.
module tb_show_sched;

  logic       ck = 1'b0;
  logic       rs_n, run, hold, skip;
  logic       en_msg, en_blink, en_wave, tick, done;
  logic [7:0] phase;

  int total = 0;
  int bad   = 0;

`ifdef SHOW_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  show_sched #(.TICK_DIV(4), .MSG_TICKS(3), .BLINK_TICKS(2), .WAVE_STEPS(5)) dut (
    .ck(ck), .rs_n(rs_n), .run(run), .hold(hold), .skip(skip),
    .en_msg(en_msg), .en_blink(en_blink), .en_wave(en_wave),
    .tick(tick), .phase(phase), .done(done)
  );

  always #5 ck = ~ck;

  typedef struct {
    int         cyc;
    logic [2:0] en;   // {msg, blink, wave}
    logic       tk;
    logic [7:0] ph;
    logic       dn;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [11:0] ex(input logic [2:0] en, input logic tk,
                                     input logic [7:0] ph, input logic dn);
    return {en, tk, ph, dn};
  endfunction

  function automatic logic [11:0] obs();
    return {en_msg, en_blink, en_wave, tick, phase, done};
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {en,tick,phase,done}=%h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    rs_n = 1'b0; run = 1'b0; hold = 1'b0; skip = 1'b0;
    cyc();
    cyc();
    rs_n = 1'b1;
    chk("reset", obs(), 12'd0);
  endtask

  initial begin
    int idx;
    int nticks;
    logic [2:0] end_en;
    logic [7:0] end_ph;

    end_en = LOOP ? 3'b100 : 3'b000;
    end_ph = LOOP ? 8'd2 : 8'd0;
    tbl[0]  = '{1,  3'b100, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{4,  3'b100, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{5,  3'b100, 1'b1, 8'd1, 1'b0};
    tbl[3]  = '{6,  3'b100, 1'b0, 8'd1, 1'b0};
    tbl[4]  = '{9,  3'b100, 1'b1, 8'd2, 1'b0};
    tbl[5]  = '{12, 3'b100, 1'b0, 8'd2, 1'b0};
    tbl[6]  = '{13, 3'b010, 1'b1, 8'd0, 1'b0};
    tbl[7]  = '{17, 3'b010, 1'b1, 8'd1, 1'b0};
    tbl[8]  = '{21, 3'b001, 1'b1, 8'd0, 1'b0};
    tbl[9]  = '{25, 3'b001, 1'b1, 8'd1, 1'b0};
    tbl[10] = '{37, 3'b001, 1'b1, 8'd4, 1'b0};
    tbl[11] = '{40, 3'b001, 1'b0, 8'd4, 1'b0};
    tbl[12] = '{41, end_en, 1'b1, 8'd0, 1'b1};
    tbl[13] = '{42, end_en, 1'b0, 8'd0, 1'b0};
    tbl[14] = '{50, end_en, 1'b0, end_ph, 1'b0};

    // Full pass with run held high, checked at table checkpoints.
    do_reset();
    run = 1'b1;
    idx = 0;
    nticks = 0;
    for (int c = 1; c <= 50; c++) begin
      cyc();
      if (c <= 40 && tick === 1'b1) nticks++;
      if (idx < 15 && tbl[idx].cyc == c) begin
        chk($sformatf("pass_c%0d", c), obs(), ex(tbl[idx].en, tbl[idx].tk, tbl[idx].ph, tbl[idx].dn));
        idx++;
      end
    end
    total++;
    if (nticks != 9) begin
      bad++;
      $display("FAIL tick_count: got %0d want 9", nticks);
    end
    // Rearm: run low for one edge, then high again starts MSG.
    run = 1'b0;
    cyc();
    chk("run_low", obs(), 12'd0);
    run = 1'b1;
    cyc();
    chk("rearm", obs(), ex(3'b100, 1'b0, 8'd0, 1'b0));

    // Skip in MSG at phase 1 with prescaler at 3.
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 8; c++) cyc();
    chk("pre_skip", obs(), ex(3'b100, 1'b0, 8'd1, 1'b0));
    skip = 1'b1;
    cyc();
    skip = 1'b0;
    chk("skip_now", obs(), ex(3'b010, 1'b0, 8'd0, 1'b0));
    for (int c = 10; c <= 12; c++) cyc();
    chk("skip_c12", obs(), ex(3'b010, 1'b0, 8'd0, 1'b0));
    cyc();
    chk("skip_c13", obs(), ex(3'b010, 1'b1, 8'd1, 1'b0));

    // Hold for 10 cycles in BLINK with the prescaler at 1.
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 14; c++) cyc();
    chk("pre_hold", obs(), ex(3'b010, 1'b0, 8'd0, 1'b0));
    hold = 1'b1;
    for (int c = 15; c <= 24; c++) begin
      cyc();
      chk($sformatf("hold_c%0d", c), obs(), ex(3'b010, 1'b0, 8'd0, 1'b0));
    end
    hold = 1'b0;
    cyc();
    cyc();
    chk("hold_rel26", obs(), ex(3'b010, 1'b0, 8'd0, 1'b0));
    cyc();
    chk("hold_rel27", obs(), ex(3'b010, 1'b1, 8'd1, 1'b0));

    // run low with skip mid-WAVE at phase 3.
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 33; c++) cyc();
    chk("pre_abort", obs(), ex(3'b001, 1'b1, 8'd3, 1'b0));
    run = 1'b0;
    skip = 1'b1;
    cyc();
    skip = 1'b0;
    chk("abort", obs(), 12'd0);
    cyc();
    chk("abort_after", obs(), 12'd0);

    // Reset pulse mid-BLINK with run high.
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 14; c++) cyc();
    rs_n = 1'b0;
    cyc();
    rs_n = 1'b1;
    chk("rst_mid", obs(), 12'd0);
    cyc();
    chk("rst_restart", obs(), ex(3'b100, 1'b0, 8'd0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
